// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. On an accepted start the operands and
//                carry-in are captured, then one full-adder step is performed
//                per clock, LSB first, for WIDTH cycles. The registered
//                result (sum, cout) is loaded on the edge that enters DONE,
//                and done pulses for that single cycle.
//
//  Ports
//    clk      in   1      clock, rising-edge active
//    rst_n    in   1      asynchronous active-low reset
//    start    in   1      begin an addition (honoured only in IDLE)
//    a, b     in   WIDTH  addends, captured on an accepted start
//    cin      in   1      carry-in, captured on an accepted start
//    busy     out  1      high during the WIDTH ADD cycles
//    done     out  1      one-cycle pulse, result available
//    sum      out  WIDTH  registered (a+b+cin) mod 2^WIDTH
//    cout     out  1      registered carry-out
//    s_bit    out  1      serial sum bit of the current ADD cycle
//    s_valid  out  1      qualifies s_bit, high exactly in ADD cycles
//
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             s_bit,
    output logic             s_valid
);

    // Counter must be able to hold WIDTH without wrapping.
    localparam int                 CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // One full-adder slice operating on the current LSBs and running carry.
    logic             fa_s;
    logic             fa_c;
    logic             fa_p;

    assign fa_p = a_sh_q[0] ^ b_sh_q[0];
    assign fa_s = fa_p ^ carry_q;
    assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & fa_p);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end

            ST_ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) bit has reached position 0.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == LAST_BIT) begin
                    // Take the last bit straight from the adder so sum
                    // carries the complete result on the DONE edge.
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy    = (state_q == ST_ADD);
    assign s_valid = (state_q == ST_ADD);
    assign s_bit   = (state_q == ST_ADD) & fa_s;
    assign done    = (state_q == ST_DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH = 8). A
//                cycle-level reference model derives every output from the
//                arithmetic sum a+b+cin; a compare process checks all DUT
//                outputs against it on each falling edge. Directed tests add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         s_bit;
    logic         s_valid;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .s_bit   (s_bit),
        .s_valid (s_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model. m_pos tells which cycle of an operation we are in:
    // -1 idle (or post-done), 0..W-1 the index of the sum bit being emitted,
    // W the done cycle. The expected bits come from the plain sum a+b+cin.
    // ------------------------------------------------------------------------
    int           m_pos = -1;
    logic [W:0]   m_full = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    int           m_accepts = 0;
    int           m_dones = 0;
    int           dut_dones = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  <= -1;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_pos < 0) begin
            if (start) begin
                m_full    <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_pos     <= 0;
                m_accepts <= m_accepts + 1;
            end
        end else if (m_pos < W) begin
            m_pos <= m_pos + 1;
            if (m_pos == W - 1) begin
                m_sum   <= m_full[W-1:0];
                m_cout  <= m_full[W];
                m_dones <= m_dones + 1;
            end
        end else begin
            m_pos <= -1;
        end
    end

    // Compare process: every output, every cycle.
    always @(negedge clk) begin
        logic in_add;
        in_add = (m_pos >= 0) && (m_pos < W);
        chk("busy",    32'(busy),    32'(in_add));
        chk("s_valid", 32'(s_valid), 32'(in_add));
        chk("s_bit",   32'(s_bit),   in_add ? 32'(m_full[m_pos]) : 32'd0);
        chk("done",    32'(done),    32'(m_pos == W));
        chk("sum",     32'(sum),     32'(m_sum));
        chk("cout",    32'(cout),    32'(m_cout));
        if (done === 1'b1) dut_dones++;
    end

    // ------------------------------------------------------------------------
    // Directed operation: called #1 after a rising edge with the DUT idle.
    // Returns #1 after the edge that brings the DUT back to IDLE.
    // ------------------------------------------------------------------------
    logic [W-1:0] got_bits;
    int           got_nbits;

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] esum,
                          input logic ecout, input string tag);
        bit seen;
        seen      = 1'b0;
        got_bits  = '0;
        got_nbits = 0;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;     // in-flight op must ignore these
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            if (s_valid === 1'b1) begin
                if (got_nbits < W) got_bits[got_nbits] = s_bit;
                got_nbits++;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_sum"},  32'(sum),  32'(esum));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_done",  32'(done),    32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_sbit",  32'(s_bit),   32'd0);
        chk("rst_sum",   32'(sum),     32'd0);
        chk("rst_cout",  32'(cout),    32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero operands: eight ADD cycles, all serial bits zero.
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        chk("zero_nbits", 32'(got_nbits), 32'd8);
        chk("zero_bits",  32'(got_bits),  32'h00);

        // Carry propagation edges.
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c");

        // Serial stream LSB first 1,1,1,1,1,1,1,0.
        run_op(8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0, "5a_25");
        chk("5a_25_bits", 32'(got_bits), 32'h7F);

        // start held high; operands change during ADD.
        begin
            bit seen;
            int ndone;
            a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            a = 8'h01; b = 8'h01;
            seen = 1'b0;
            for (int i = 0; i < 3 * W && !seen; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
            end
            chk("hold_done1", 32'(seen), 32'd1);
            chk("hold_sum1",  32'(sum),  32'h30);
            chk("hold_cout1", 32'(cout), 32'd0);
            // DONE -> IDLE edge, then restart accepted on the following edge.
            @(posedge clk); #1;
            chk("hold_idle_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk("hold_restart_busy", 32'(busy), 32'd1);
            start = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 3 * W && !seen; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
            end
            chk("hold_done2", 32'(seen), 32'd1);
            chk("hold_sum2",  32'(sum),  32'h02);
            @(posedge clk); #1;
            ndone = dut_dones;
            chk("hold_done_count", 32'(ndone), 32'(m_dones));
        end

        // Reset in 4th ADD cycle of 0xFF + 0x01.
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  32'(busy),    32'd0);
        chk("abort_done",  32'(done),    32'd0);
        chk("abort_valid", 32'(s_valid), 32'd0);
        chk("abort_sbit",  32'(s_bit),   32'd0);
        chk("abort_sum",   32'(sum),     32'd0);
        chk("abort_cout",  32'(cout),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_abort_sum",  32'(sum),  32'd0);
        chk("post_abort_cout", 32'(cout), 32'd0);
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "03_04");

        // Random operands against plain arithmetic.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            logic [W:0]   ref_full;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, ref_full[W-1:0], ref_full[W], "rand");
        end

        // One operation was aborted by reset; every other accept must finish.
        chk("done_vs_model",   32'(dut_dones), 32'(m_dones));
        chk("done_vs_accepts", 32'(dut_dones), 32'(m_accepts - 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port a  input  WIDTH  addend A; captured only on an accepted start.
REQ-006 Port b  input  WIDTH  addend B; captured only on an accepted start.
REQ-007 Port cin  input  1  carry-in; captured only on an accepted start.
REQ-008 Port busy  output  1  high while an addition is in progress (ADD state).
REQ-009 Port done  output  1  single-cycle pulse marking that a result is available.
REQ-010 Port sum  output  WIDTH  registered result of a+b+cin, low WIDTH bits.
REQ-011 Port cout  output  1  registered carry-out of the result.
REQ-012 Port s_bit  output  1  serial sum bit produced in the current ADD cycle, LSB first.
REQ-013 Port s_valid  output  1  qualifies s_bit; high exactly in ADD cycles.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, ADD, DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL latch a, b and cin into internal shift/carry registers, clear the bit counter and enter ADD.
REQ-016 start SHALL be ignored in ADD and DONE; no operand capture, no restart.
REQ-017 Each ADD cycle SHALL apply one full-adder step to (a_sh[0], b_sh[0], carry): s = a^b^c, c' = a&b | c&(a^b).
REQ-018 Each ADD edge SHALL shift a_sh and b_sh right by one, store c' into carry, shift s into the MSB of an internal result shift register, and increment the counter.
REQ-019 s_bit SHALL equal the combinational s of the current ADD cycle; s_valid=1 in ADD, 0 otherwise.
REQ-020 After exactly WIDTH ADD cycles the FSM SHALL enter DONE; counter width SHALL be ceil(log2(WIDTH+1)) bits, with no wrap before termination.
REQ-021 On the edge entering DONE, sum SHALL load the full result register and cout the final carry; both SHALL otherwise hold their value until the next such edge.
REQ-022 done SHALL be 1 for exactly the one DONE cycle; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-023 Latency: start accepted at edge k -> busy high for edges k..k+WIDTH-1 window, done high in cycle after edge k+WIDTH, next start accepted at edge k+WIDTH+2 at earliest.
REQ-024 Result SHALL equal (a+b+cin) mod 2^WIDTH with cout = bit WIDTH of that sum, for all operand values, including all-ones inputs.
REQ-025 Operand inputs changing during ADD SHALL not affect the in-flight result.

Reset
REQ-026 rst_n=0 SHALL immediately, without clk, force state IDLE, busy=0, done=0, s_valid=0, s_bit=0, sum=0, cout=0, and clear counter, carry and shift registers.
REQ-027 Reset asserted mid-ADD SHALL abort the operation; no done pulse and no sum/cout update SHALL follow deassertion.
REQ-028 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 a=0x00, b=0x00, cin=0, start one cycle -> busy 8 cycles, done pulse once, sum=0x00, cout=0, s_bit all 0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 a=0x5A, b=0x25, cin=0 -> serial s_bit sequence LSB-first 1,1,1,1,1,1,1,0 and sum=0x7F, cout=0.
REQ-032 start held high continuously with a=0x10, b=0x20 changing to 0x01/0x01 during ADD -> result 0x30 only; ignored in ADD/DONE; new op begins on first IDLE edge.
REQ-033 rst_n pulsed low in 4th ADD cycle of 0xFF+0x01 -> all outputs 0 at once, no done, sum stays 0x00/cout 0; then 0x03+0x04 -> sum=0x07.
REQ-034 Randomized 1000 operand/cin triples against reference a+b+cin: sum and cout match at every done, done count equals accepted starts.
